// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder: rebuilds MM:SS frames from a scanned 4-digit 7-seg bus. Rev 1.0
// ============================================================================
module seg7_scan_decoder #(
  parameter bit          CC            = 1'b1,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seven_seg_in,
  input  logic [3:0]  digit_en_in,
  input  logic        err_clr,
  output logic [15:0] time_bcd,
  output logic        frame_valid,
  output logic [15:0] frame_cnt,
  output logic        seg_err,
  output logic        en_err,
  output logic        stale
);

  localparam logic [7:0]  c_QUAL    = 8'(STABLE_CYCLES - 1);
  localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT);

  // Returns {valid, digit} for a normalized (0 = lit) segment pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = {1'b1, 4'd0};
      7'b1001111: decode = {1'b1, 4'd1};
      7'b0010010: decode = {1'b1, 4'd2};
      7'b0000110: decode = {1'b1, 4'd3};
      7'b1001100: decode = {1'b1, 4'd4};
      7'b0100100: decode = {1'b1, 4'd5};
      7'b0100000: decode = {1'b1, 4'd6};
      7'b0001111: decode = {1'b1, 4'd7};
      7'b0000000: decode = {1'b1, 4'd8};
      7'b0000100: decode = {1'b1, 4'd9};
      default:    decode = {1'b0, 4'd0};
    endcase
  endfunction

  logic [10:0] r_sync1, r_sync2, r_prev;
  logic [7:0]  r_stab;
  logic        r_done;
  logic [15:0] r_shadow;
  logic [3:0]  r_mask;
  logic [15:0] r_time;
  logic        r_fv;
  logic [15:0] r_fcnt;
  logic        r_seg_err, r_en_err;
  logic [31:0] r_to;

  logic [10:0] w_pat;
  logic        w_change, w_qual;
  logic [3:0]  w_cap_en;
  logic [4:0]  w_dec;
  logic        w_blank, w_multi, w_onehot;
  logic        w_cap_ok, w_seg_bad, w_en_bad, w_mask_full;

  assign w_pat    = CC ? ~r_sync2 : r_sync2;
  assign w_change = (w_pat != r_prev);

  // r_prev is the pattern under test; r_stab == k means it has held k+1 cycles.
  assign w_qual   = (r_stab == c_QUAL) && !r_done;
  assign w_cap_en = r_prev[10:7];
  assign w_dec    = decode(r_prev[6:0]);
  assign w_blank  = (w_cap_en == 4'd0);
  assign w_multi  = ((w_cap_en & (w_cap_en - 4'd1)) != 4'd0);
  assign w_onehot = !w_blank && !w_multi;

  assign w_cap_ok    = w_qual && w_onehot && w_dec[4];
  assign w_seg_bad   = w_qual && w_onehot && !w_dec[4];
  assign w_en_bad    = w_qual && w_multi;
  assign w_mask_full = (r_mask == 4'hF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_stab  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_sync1 <= {digit_en_in, seven_seg_in};
      r_sync2 <= r_sync1;
      r_prev  <= w_pat;
      if (w_change) begin
        r_stab <= '0;
        r_done <= 1'b0;
      end else begin
        if (r_stab != 8'hFF) r_stab <= r_stab + 8'd1;
        if (w_qual) r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_mask    <= '0;
      r_time    <= '0;
      r_fv      <= 1'b0;
      r_fcnt    <= '0;
      r_seg_err <= 1'b0;
      r_en_err  <= 1'b0;
      r_to      <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_cap_ok && w_cap_en[i]) r_shadow[4*i +: 4] <= w_dec[3:0];
      end
      // A capture landing on the frame-close cycle survives the mask clear.
      r_mask <= (w_mask_full ? 4'h0 : r_mask) | (w_cap_ok ? w_cap_en : 4'h0);
      r_fv   <= w_mask_full;
      if (w_mask_full) begin
        r_time <= r_shadow;
        r_fcnt <= r_fcnt + 16'd1;
      end
      r_seg_err <= w_seg_bad || (r_seg_err && !err_clr);
      r_en_err  <= w_en_bad  || (r_en_err  && !err_clr);
      if (w_cap_ok)              r_to <= '0;
      else if (r_to != c_TIMEOUT) r_to <= r_to + 32'd1;
    end
  end

  assign time_bcd    = r_time;
  assign frame_valid = r_fv;
  assign frame_cnt   = r_fcnt;
  assign seg_err     = r_seg_err;
  assign en_err      = r_en_err;
  assign stale       = (r_to == c_TIMEOUT);

endmodule
`default_nettype wire
